// File: rtl/gcd_stream_if.sv
// Operand and result handshake bundle for gcd_stream.
// The master side is the operand producer and result consumer; the slave side is the engine.
interface gcd_stream_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] gcd_out;
    logic [CNT_W-1:0] iter_out;
    logic             zero_err;

    modport master (
        output in_valid, a_in, b_in, out_ready,
        input  in_ready, out_valid, gcd_out, iter_out, zero_err
    );

    modport slave (
        input  in_valid, a_in, b_in, out_ready,
        output in_ready, out_valid, gcd_out, iter_out, zero_err
    );
endinterface

// File: rtl/gcd_stream.sv
// Subtractive-Euclid GCD engine: one subtract per cycle, valid/ready on both sides,
// explicit zero-operand handling and a saturating step counter.
module gcd_stream #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic           clk,
    input  logic           rst,
    gcd_stream_if.slave    bus,
    output logic           busy
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [WIDTH-1:0] gcd_q, gcd_d;
    logic [CNT_W-1:0] iter_q, iter_d;
    logic             zero_q, zero_d;
    logic             in_ready;
    logic             accept;

    assign in_ready = (state_q == IDLE) && !rst;
    assign accept   = bus.in_valid && in_ready;

    // NOTE: every register, datapath included, is cleared by reset so the
    // result outputs read back as zero straight after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            gcd_q   <= '0;
            iter_q  <= '0;
            zero_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register updates from the same
            // pre-edge values, no matter the statement order.
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            gcd_q   <= gcd_d;
            iter_q  <= iter_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        // NOTE: hold-by-default first, so no path leaves a signal unassigned
        // and no latch is inferred.
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        gcd_d   = gcd_q;
        iter_d  = iter_q;
        zero_d  = zero_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    ra_d   = bus.a_in;
                    rb_d   = bus.b_in;
                    iter_d = '0;
                    zero_d = 1'b0;
                    if (bus.a_in == '0 && bus.b_in == '0) begin
                        gcd_d   = '0;
                        zero_d  = 1'b1;
                        state_d = DONE;
                    end else if (bus.a_in == '0) begin
                        gcd_d   = bus.b_in;
                        state_d = DONE;
                    end else if (bus.b_in == '0) begin
                        gcd_d   = bus.a_in;
                        state_d = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (ra_q == rb_q) begin
                    gcd_d   = ra_q;
                    state_d = DONE;
                end else begin
                    // Larger operand is always the minuend, so no underflow.
                    if (ra_q > rb_q) ra_d = ra_q - rb_q;
                    else             rb_d = rb_q - ra_q;
                    if (iter_q != {CNT_W{1'b1}}) iter_d = iter_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == DONE);
    assign bus.gcd_out   = gcd_q;
    assign bus.iter_out  = iter_q;
    assign bus.zero_err  = zero_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_gcd_stream.sv
// Directed and randomised checks of gcd_stream: result, step count, latency,
// zero handling, saturation, backpressure and mid-calculation reset.
module tb_gcd_stream;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gcd_stream_if #(.WIDTH(16), .CNT_W(16)) m_if ();
    gcd_stream_if #(.WIDTH(16), .CNT_W(4))  s_if ();
    gcd_stream_if #(.WIDTH(8),  .CNT_W(16)) r_if ();
    logic m_busy, s_busy, r_busy;

    gcd_stream #(.WIDTH(16), .CNT_W(16)) u_main (.clk(clk), .rst(rst), .bus(m_if.slave), .busy(m_busy));
    gcd_stream #(.WIDTH(16), .CNT_W(4))  u_sat  (.clk(clk), .rst(rst), .bus(s_if.slave), .busy(s_busy));
    gcd_stream #(.WIDTH(8),  .CNT_W(16)) u_rnd  (.clk(clk), .rst(rst), .bus(r_if.slave), .busy(r_busy));

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] gcd;
        int          iter;
        logic        zero;
        int          lat;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_main(input int limit, output int cyc);
        cyc = 1;
        while (!m_if.out_valid && cyc < limit) begin
            tick();
            cyc++;
        end
    endtask

    task automatic run_main(input int idx, input vec_t v);
        int cyc;
        check($sformatf("vec%0d in_ready idle", idx), m_if.in_ready, 1);
        m_if.a_in      = v.a;
        m_if.b_in      = v.b;
        m_if.in_valid  = 1'b1;
        m_if.out_ready = 1'b1;
        tick();
        m_if.in_valid = 1'b0;
        wait_main(v.lat + 10, cyc);
        check($sformatf("vec%0d latency", idx), cyc, v.lat);
        check($sformatf("vec%0d out_valid", idx), m_if.out_valid, 1);
        check($sformatf("vec%0d gcd", idx), m_if.gcd_out, v.gcd);
        check($sformatf("vec%0d iter", idx), m_if.iter_out, v.iter);
        check($sformatf("vec%0d zero_err", idx), m_if.zero_err, v.zero);
        tick();
        check($sformatf("vec%0d in_ready after", idx), m_if.in_ready, 1);
        check($sformatf("vec%0d out_valid after", idx), m_if.out_valid, 0);
    endtask

    function automatic void ref_gcd(input int a, input int b, output int g, output int k);
        k = 0;
        if (a == 0) g = b;
        else if (b == 0) g = a;
        else begin
            while (a != b) begin
                if (a > b) a = a - b;
                else       b = b - a;
                k++;
            end
            g = a;
        end
    endfunction

    vec_t vecs[12];

    initial begin
        int cyc;

        vecs[0]  = '{16'd12,    16'd18, 16'd6,     2,     1'b0, 4};
        vecs[1]  = '{16'd7,     16'd7,  16'd7,     0,     1'b0, 2};
        vecs[2]  = '{16'd0,     16'd9,  16'd9,     0,     1'b0, 1};
        vecs[3]  = '{16'd9,     16'd0,  16'd9,     0,     1'b0, 1};
        vecs[4]  = '{16'd0,     16'd0,  16'd0,     0,     1'b1, 1};
        vecs[5]  = '{16'd48,    16'd36, 16'd12,    3,     1'b0, 5};
        vecs[6]  = '{16'd5,     16'd10, 16'd5,     1,     1'b0, 3};
        vecs[7]  = '{16'd65535, 16'd0,  16'd65535, 0,     1'b0, 1};
        vecs[8]  = '{16'd1,     16'd1,  16'd1,     0,     1'b0, 2};
        vecs[9]  = '{16'd100,   16'd75, 16'd25,    3,     1'b0, 5};
        vecs[10] = '{16'd13,    16'd1,  16'd1,     12,    1'b0, 14};
        vecs[11] = '{16'd65535, 16'd1,  16'd1,     65534, 1'b0, 65536};

        {m_if.in_valid, m_if.out_ready, m_if.a_in, m_if.b_in} = '0;
        {s_if.in_valid, s_if.out_ready, s_if.a_in, s_if.b_in} = '0;
        {r_if.in_valid, r_if.out_ready, r_if.a_in, r_if.b_in} = '0;

        // Reset state.
        tick();
        check("in_ready during rst", m_if.in_ready, 0);
        check("out_valid during rst", m_if.out_valid, 0);
        rst = 1'b0;
        tick();
        check("reset in_ready", m_if.in_ready, 1);
        check("reset busy", m_busy, 0);
        check("reset gcd", m_if.gcd_out, 0);
        check("reset iter", m_if.iter_out, 0);
        check("reset zero_err", m_if.zero_err, 0);

        for (int i = 0; i < 12; i++) run_main(i, vecs[i]);

        // Backpressure: (48,36) held in DONE while (5,10) is offered.
        m_if.a_in = 16'd48; m_if.b_in = 16'd36;
        m_if.in_valid = 1'b1; m_if.out_ready = 1'b0;
        tick();
        m_if.a_in = 16'd5; m_if.b_in = 16'd10;
        wait_main(20, cyc);
        check("bp latency", cyc, 5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp%0d out_valid", i), m_if.out_valid, 1);
            check($sformatf("bp%0d gcd", i), m_if.gcd_out, 12);
            check($sformatf("bp%0d iter", i), m_if.iter_out, 3);
            check($sformatf("bp%0d in_ready", i), m_if.in_ready, 0);
            check($sformatf("bp%0d busy", i), m_busy, 1);
            tick();
        end
        check("bp held gcd", m_if.gcd_out, 12);
        m_if.out_ready = 1'b1;
        tick();
        check("bp in_ready after", m_if.in_ready, 1);
        tick();
        m_if.in_valid = 1'b0;
        wait_main(20, cyc);
        check("bp2 latency", cyc, 3);
        check("bp2 gcd", m_if.gcd_out, 5);
        check("bp2 iter", m_if.iter_out, 1);
        tick();

        // Reset pulse in the middle of (1000,3).
        m_if.a_in = 16'd1000; m_if.b_in = 16'd3; m_if.in_valid = 1'b1;
        tick();
        m_if.in_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("mid busy", m_busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rst out_valid", m_if.out_valid, 0);
        check("rst gcd", m_if.gcd_out, 0);
        check("rst iter", m_if.iter_out, 0);
        check("rst in_ready", m_if.in_ready, 1);
        check("rst busy", m_busy, 0);
        tick();
        m_if.a_in = 16'd9; m_if.b_in = 16'd6; m_if.in_valid = 1'b1;
        tick();
        m_if.in_valid = 1'b0;
        wait_main(20, cyc);
        check("post rst latency", cyc, 4);
        check("post rst gcd", m_if.gcd_out, 3);
        check("post rst iter", m_if.iter_out, 2);
        tick();

        // Saturating counter with CNT_W=4: (20,1) takes 19 steps.
        s_if.a_in = 16'd20; s_if.b_in = 16'd1; s_if.in_valid = 1'b1; s_if.out_ready = 1'b1;
        tick();
        s_if.in_valid = 1'b0;
        cyc = 1;
        while (!s_if.out_valid && cyc < 40) begin
            tick();
            cyc++;
        end
        check("sat latency", cyc, 21);
        check("sat gcd", s_if.gcd_out, 1);
        check("sat iter", s_if.iter_out, 15);
        tick();
        check("sat in_ready after", s_if.in_ready, 1);

        // Random WIDTH=8 pairs with throttled out_ready.
        for (int n = 0; n < 30; n++) begin
            int  a, b, g, k, lat;
            bit  seen, done;
            a = (n % 7 == 3) ? 0 : int'($urandom_range(0, 255));
            b = (n % 11 == 5) ? 0 : int'($urandom_range(1, 255));
            ref_gcd(a, b, g, k);
            lat = (a == 0 || b == 0) ? 1 : k + 2;
            check($sformatf("rnd%0d in_ready", n), r_if.in_ready, 1);
            r_if.a_in = 8'(a); r_if.b_in = 8'(b); r_if.in_valid = 1'b1;
            tick();
            r_if.in_valid = 1'b0;
            seen = 1'b0;
            done = 1'b0;
            cyc  = 1;
            while (!done && cyc < 600) begin
                r_if.out_ready = 1'($urandom_range(0, 1));
                if (r_if.out_valid && !seen) begin
                    seen = 1'b1;
                    check($sformatf("rnd%0d latency", n), cyc, lat);
                end
                if (r_if.out_valid) begin
                    check($sformatf("rnd%0d gcd", n), r_if.gcd_out, g);
                    check($sformatf("rnd%0d iter", n), r_if.iter_out, k);
                    check($sformatf("rnd%0d zero_err", n), r_if.zero_err, (a == 0 && b == 0) ? 1 : 0);
                end
                if (r_if.out_valid && r_if.out_ready) done = 1'b1;
                tick();
                cyc++;
            end
            check($sformatf("rnd%0d handshake", n), done, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gcd_stream.md
# gcd_stream

Parametrised GCD engine with integrated sequencing: accepts an operand pair over a valid/ready handshake, runs subtractive Euclid (one subtract per cycle), and returns the result with an iteration count over a second valid/ready handshake. Successor to the fixed 16-bit datapath/controller pair. Zero operands are handled explicitly, width is generic, and backpressure is supported. Sits between an operand producer (e.g. a register interface or test sequencer) and a result consumer.

## Interface
- WIDTH, 16, operand/result width in bits (≥2)
- CNT_W, 16, iteration-counter width in bits (≥1)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  engine can accept operands
- a_in  in  WIDTH  operand A (unsigned)
- b_in  in  WIDTH  operand B (unsigned)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- gcd_out  out  WIDTH  result
- iter_out  out  CNT_W  number of subtract steps taken, saturating
- zero_err  out  1  both operands were zero (gcd_out = 0)
- busy  out  1  state != IDLE

## Operation
- States: IDLE, CALC, DONE. Internal registers rA, rB (WIDTH), iter (CNT_W).
- IDLE: in_ready = 1. On in_valid & in_ready, load rA=a_in, rB=b_in, clear iter and zero_err.
  - a_in=0 and b_in=0 → gcd_out=0, zero_err=1, go to DONE.
  - Exactly one operand is 0 → gcd_out = the nonzero operand, go to DONE.
  - Otherwise go to CALC.
- CALC (one step per cycle, unsigned compare of rA and rB):
  - rA == rB → gcd_out=rA, go to DONE; iter unchanged.
  - rA > rB → rA <= rA − rB; iter++.
  - rA < rB → rB <= rB − rA; iter++.
  - iter saturates at 2^CNT_W − 1. gcd_out is still exact.
  - Subtraction is WIDTH bits. The larger operand is always the minuend, so no underflow occurs.
- DONE: out_valid = 1. gcd_out, iter_out and zero_err stay stable until out_valid & out_ready. On that handshake go to IDLE.
- in_ready is 0 outside IDLE. in_valid in CALC/DONE is ignored, and no operands are captured.
- No back-to-back overlap: the next pair can be accepted no earlier than the cycle after the result handshake.
- Outputs gcd_out/iter_out/zero_err keep their last values in IDLE and CALC until overwritten. Consumers qualify them with out_valid.

## Timing
- Reset: when rst is sampled high at an edge, next state is IDLE, and gcd_out=0, iter_out=0, zero_err=0, out_valid=0. in_ready is forced 0 while rst is high and is 1 from the first cycle after rst deasserts. busy=0.
- rst overrides everything, including mid-CALC and DONE with a pending result. The pending result is discarded.
- Acceptance cycle = cycle 0 (in_valid & in_ready sampled high at its closing edge).
- Nonzero operands, k subtract steps: CALC occupies cycles 1..k+1, and out_valid is first high in cycle k+2.
- Any zero operand: out_valid is first high in cycle 1, with iter_out=0.
- Worst case for WIDTH=16 is (65535,1): k = 65534.
- out_valid stays high until the cycle in which out_ready is sampled high. in_ready is high in the following cycle.
- All outputs are driven from registers or the state decode, with no combinational path from in_valid/out_ready to any output.

## Test plan
- Reset, then (12,18) → rB:6, rA:6; gcd_out=6, iter_out=2, out_valid first high in cycle 4, zero_err=0.
- (7,7) → gcd_out=7, iter_out=0, out_valid in cycle 2. (0,9) → gcd_out=9, iter_out=0, out_valid in cycle 1. (0,0) → gcd_out=0, zero_err=1, cycle 1.
- WIDTH=16 (65535,1) → gcd_out=1, iter_out=65534, out_valid in cycle 65536. With CNT_W=4, (20,1) → gcd_out=1, iter_out=15 (saturated), out_valid in cycle 21.
- Backpressure: (48,36) with out_ready held low 5 cycles after out_valid rises → gcd_out=12, iter_out=3. Outputs stay stable and in_ready stays 0. A pair (5,10) presented during that time is not captured. After the handshake, in_ready=1 the next cycle, and (5,10) then yields 5, iter_out=1.
- rst pulsed for 1 cycle mid-CALC of (1000,3) → next cycle out_valid=0, gcd_out=0, iter_out=0, in_ready=1, busy=0. A following (9,6) → gcd_out=3, iter_out=2.
- Randomised WIDTH=8 pairs checked against a reference GCD model for result and step count, with random out_ready throttling.
